// File: rtl/uart_core_if.sv
// uart_core_if: host-side valid/ready handshakes of uart_core.
// master = host logic, slave = the UART.
interface uart_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_frame_err;
    logic                 rx_parity_err;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_frame_err,
        input  rx_parity_err, rx_valid, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_frame_err,
        output rx_parity_err, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// uart_core: full-duplex UART, baud generation, TX/RX FSMs, show-ahead RX FIFO.
// Define UART_PARITY_EN to insert and check a parity bit after the data bits.
module uart_core #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int BIT_RATE      = 9600,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int PARITY_ODD    = 0,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    uart_core_if.slave ifc,
    output logic       tx_pin,
    input  logic       rx_pin
);
    localparam int CPB = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CPB);
    localparam int AW  = $clog2(RX_FIFO_DEPTH);
    localparam int EW  = DATA_BITS + 2;

    localparam logic [CW-1:0] CPB_M1    = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1   = CW'(CPB / 2 - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
    localparam logic          ODD       = 1'(PARITY_ODD);
`endif

    localparam logic [2:0] TX_IDLE  = 3'd0;
    localparam logic [2:0] TX_START = 3'd1;
    localparam logic [2:0] TX_DATA  = 3'd2;
    localparam logic [2:0] TX_STOP  = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] TX_PAR   = 3'd4;
`endif

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] RX_PAR   = 3'd4;
`endif
    localparam logic [2:0] RX_WAIT  = 3'd5;

    logic [2:0]           tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [3:0]           tx_bit;
    logic                 tx_stop;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_tick;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_tick      = (tx_cnt == '0);
    assign ifc.tx_ready = (tx_state == TX_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_state <= TX_IDLE;
            tx_pin   <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_sh    <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            if (tx_state != TX_IDLE)
                tx_cnt <= tx_tick ? CPB_M1 : tx_cnt - 1'b1;
            unique case (tx_state)
                TX_IDLE: if (ifc.tx_valid) begin
                    tx_state <= TX_START;
                    tx_pin   <= 1'b0;
                    tx_sh    <= ifc.tx_data;
                    tx_cnt   <= CPB_M1;
`ifdef UART_PARITY_EN
                    tx_par   <= ^ifc.tx_data ^ ODD;
`endif
                end
                TX_START: if (tx_tick) begin
                    tx_state <= TX_DATA;
                    tx_pin   <= tx_sh[0];
                    tx_sh    <= tx_sh >> 1;
                    tx_bit   <= '0;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        tx_state <= TX_PAR;
                        tx_pin   <= tx_par;
`else
                        tx_state <= TX_STOP;
                        tx_pin   <= 1'b1;
                        tx_stop  <= 1'b0;
`endif
                    end else begin
                        tx_pin <= tx_sh[0];
                        tx_sh  <= tx_sh >> 1;
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                TX_PAR: if (tx_tick) begin
                    tx_state <= TX_STOP;
                    tx_pin   <= 1'b1;
                    tx_stop  <= 1'b0;
                end
`endif
                TX_STOP: if (tx_tick) begin
                    if (tx_stop == LAST_STOP)
                        tx_state <= TX_IDLE;
                    else
                        tx_stop <= tx_stop + 1'b1;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    logic                 rx_s1, rx_s2, rx_s3;
    logic [2:0]           rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [3:0]           rx_bit;
    logic                 rx_stop;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_ferr;
    logic                 rx_perr;
    logic                 rx_tick;
    logic                 rx_busy;
    logic                 ferr_now;
    logic                 push;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_pin;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_tick  = (rx_cnt == '0);
    assign rx_busy  = (rx_state != RX_IDLE) && (rx_state != RX_WAIT);
    assign ferr_now = rx_ferr | ~rx_s2;
    assign push     = (rx_state == RX_STOP) && rx_tick &&
                      (rx_stop == LAST_STOP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_stop  <= 1'b0;
            rx_sh    <= '0;
            rx_ferr  <= 1'b0;
            rx_perr  <= 1'b0;
        end else begin
            if (rx_busy)
                rx_cnt <= rx_tick ? CPB_M1 : rx_cnt - 1'b1;
            unique case (rx_state)
                RX_IDLE: if (rx_s3 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= HALF_M1;
                end
                // a start bit that is high again at mid-bit is a glitch
                RX_START: if (rx_tick) begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_state <= RX_DATA;
                        rx_bit   <= '0;
                        rx_perr  <= 1'b0;
                    end
                end
                RX_DATA: if (rx_tick) begin
                    rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                    if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        rx_state <= RX_PAR;
`else
                        rx_state <= RX_STOP;
`endif
                        rx_stop  <= 1'b0;
                        rx_ferr  <= 1'b0;
                    end else begin
                        rx_bit <= rx_bit + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PAR: if (rx_tick) begin
                    rx_perr  <= rx_s2 ^ (^rx_sh) ^ ODD;
                    rx_state <= RX_STOP;
                end
`endif
                RX_STOP: if (rx_tick) begin
                    rx_ferr <= ferr_now;
                    if (rx_stop == LAST_STOP)
                        rx_state <= ferr_now ? RX_WAIT : RX_IDLE;
                    else
                        rx_stop <= rx_stop + 1'b1;
                end
                RX_WAIT: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // wrap bit on each pointer separates full from empty
    logic [EW-1:0] mem [RX_FIFO_DEPTH];
    logic [EW-1:0] head;
    logic [AW:0]   wp, rp;
    logic          empty, full, pop, wr;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop   = ifc.rx_ready && !empty;
    assign wr    = push && (!full || pop);
    assign head  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp             <= '0;
            rp             <= '0;
            ifc.rx_overrun <= 1'b0;
        end else begin
            if (wr)  wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            ifc.rx_overrun <= push && full && !pop;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= {rx_perr, ferr_now, rx_sh};
    end

    assign ifc.rx_valid      = !empty;
    assign ifc.rx_data       = empty ? '0 : head[DATA_BITS-1:0];
    assign ifc.rx_frame_err  = !empty && head[DATA_BITS];
`ifdef UART_PARITY_EN
    assign ifc.rx_parity_err = !empty && head[DATA_BITS+1];
`else
    assign ifc.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed bench for uart_core at CPB = 10.
// Parity steps are built only when UART_PARITY_EN is defined.
module tb_uart_core;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx_drv = 1'b1;
    logic loop = 1'b0;
    logic tx_pin;
    logic rx_pin;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ovr_cnt = 0;
`ifdef UART_PARITY_EN
    logic flip_par = 1'b0;
`endif

    assign rx_pin = loop ? tx_pin : rx_drv;

    uart_core_if #(.DATA_BITS(8)) ifc ();

    uart_core #(
        .CLK_HZ(1_000_000),
        .BIT_RATE(100_000),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .PARITY_ODD(0),
        .RX_FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ifc(ifc),
        .tx_pin(tx_pin),
        .rx_pin(rx_pin)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ifc.rx_overrun === 1'b1) ovr_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        ifc.tx_data  = d;
        ifc.tx_valid = 1'b1;
        @(posedge clk);
        #1 ifc.tx_valid = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (10) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit((^d) ^ flip_par);
`endif
        drive_bit(stop);
    endtask

    task automatic pop_one();
        @(negedge clk);
        ifc.rx_ready = 1'b1;
        @(negedge clk);
        ifc.rx_ready = 1'b0;
    endtask

    logic [9:0]  fr10;
`ifdef UART_PARITY_EN
    logic [10:0] fr11;
`endif

    initial begin
        ifc.tx_data  = '0;
        ifc.tx_valid = 1'b0;
        ifc.rx_ready = 1'b0;

        @(negedge clk);
        check("rst_tx_pin", tx_pin, 1);
        check("rst_tx_ready", ifc.tx_ready, 1);
        check("rst_rx_valid", ifc.rx_valid, 0);
        check("rst_rx_data", ifc.rx_data, 0);
        check("rst_ferr", ifc.rx_frame_err, 0);
        check("rst_perr", ifc.rx_parity_err, 0);
        check("rst_overrun", ifc.rx_overrun, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

`ifndef UART_PARITY_EN
        // TX 0xA5: both ends of every bit window
        fr10 = {1'b1, 8'hA5, 1'b0};
        send_tx(8'hA5);
        for (int k = 1; k <= 101; k++) begin
            @(negedge clk);
            if (k <= 100 && (k % 10 == 1 || k % 10 == 0))
                check($sformatf("tx_a5_k%0d", k), tx_pin, fr10[(k-1)/10]);
            if (k == 100) check("tx_busy_end", ifc.tx_ready, 0);
            if (k == 101) check("tx_ready_ret", ifc.tx_ready, 1);
        end
        repeat (5) @(negedge clk);

        // loopback 0x3C, exact RX latency
        loop = 1'b1;
        send_tx(8'h3C);
        for (int k = 1; k <= 99; k++) begin
            @(negedge clk);
            if (k == 98) check("lb_valid_early", ifc.rx_valid, 0);
            if (k == 99) check("lb_valid", ifc.rx_valid, 1);
        end
        check("lb_data", ifc.rx_data, 8'h3C);
        check("lb_ferr", ifc.rx_frame_err, 0);
        check("lb_perr", ifc.rx_parity_err, 0);
        pop_one();
        check("lb_pop_empty", ifc.rx_valid, 0);
        repeat (10) @(negedge clk);
        loop = 1'b0;
        repeat (5) @(negedge clk);

        // frame error, line held low afterwards
        rx_frame(8'h55, 1'b0);
        repeat (30) @(negedge clk);
        check("fe_valid", ifc.rx_valid, 1);
        check("fe_data", ifc.rx_data, 8'h55);
        check("fe_ferr", ifc.rx_frame_err, 1);
        check("fe_perr", ifc.rx_parity_err, 0);
        pop_one();
        repeat (20) @(negedge clk);
        check("fe_no_second_low", ifc.rx_valid, 0);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("fe_no_second_high", ifc.rx_valid, 0);

        // overrun: five frames into a four-entry FIFO
        for (int i = 1; i <= 4; i++) rx_frame(8'(i), 1'b1);
        repeat (5) @(negedge clk);
        check("ovr_none_yet", ovr_cnt, 0);
        check("ovr_full_valid", ifc.rx_valid, 1);
        rx_frame(8'h05, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_pulse", ovr_cnt, 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_valid_%0d", i), ifc.rx_valid, 1);
            check($sformatf("ovr_data_%0d", i), ifc.rx_data, i);
            pop_one();
        end
        check("ovr_drained", ifc.rx_valid, 0);
        pop_one();
        check("ovr_pop_empty", ifc.rx_valid, 0);

        // glitch, then a normal frame proves RX is back in IDLE
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_no_push", ifc.rx_valid, 0);
        rx_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        check("post_glitch_valid", ifc.rx_valid, 1);
        check("post_glitch_data", ifc.rx_data, 8'h81);
        check("post_glitch_ferr", ifc.rx_frame_err, 0);
`else
        // TX 0x07 with even parity: parity bit 1, 110-cycle frame
        fr11 = {1'b1, 1'b1, 8'h07, 1'b0};
        send_tx(8'h07);
        for (int k = 1; k <= 111; k++) begin
            @(negedge clk);
            if (k <= 110 && k % 10 == 5)
                check($sformatf("txp_k%0d", k), tx_pin, fr11[k/10]);
            if (k == 110) check("txp_busy_end", ifc.tx_ready, 0);
            if (k == 111) check("txp_ready_ret", ifc.tx_ready, 1);
        end
        repeat (5) @(negedge clk);

        // RX 0x07 with parity bit 0
        flip_par = 1'b1;
        rx_frame(8'h07, 1'b1);
        flip_par = 1'b0;
        repeat (10) @(negedge clk);
        check("rxp_valid", ifc.rx_valid, 1);
        check("rxp_data", ifc.rx_data, 8'h07);
        check("rxp_perr", ifc.rx_parity_err, 1);
        check("rxp_ferr", ifc.rx_frame_err, 0);
        pop_one();
        rx_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        check("rxp_good_data", ifc.rx_data, 8'h81);
        check("rxp_good_perr", ifc.rx_parity_err, 0);
`endif

        // reset mid-frame with one entry held in the FIFO
        send_tx(8'h00);
        repeat (30) @(negedge clk);
        check("mid_tx_low", tx_pin, 0);
        check("mid_tx_busy", ifc.tx_ready, 0);
        resetn = 1'b0;
        #1;
        check("arst_tx_pin", tx_pin, 1);
        check("arst_tx_ready", ifc.tx_ready, 1);
        check("arst_rx_valid", ifc.rx_valid, 0);
        check("arst_rx_data", ifc.rx_data, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_tx_pin", tx_pin, 1);
        check("ovr_total", ovr_cnt, 1 - 0 * n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
